lsu_ctrl: RTL

- Multi-cycle load/store controller that sits directly downstream of the ALU.
- Consumes the ALU result as an effective address and issues one request to the data-memory bus.
- Performs byte-lane steering and load sign/zero extension.
- Hands the load data or an error flag to writeback through a valid/ready handshake.

---
 rtl/lsu_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller between the ALU and the data-memory bus: issues one bus
// request per op, steers store lanes, extends load data, and hands the result to writeback.
module lsu_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  // state | meaning
  // IDLE  | waiting for an op; in_ready high
  // REQ   | bus request held until mem_req_ready
  // WAIT  | waiting for response / write ack, timeout counter running
  // DONE  | result presented to writeback until out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic              mem_wen_q;
  logic [31:0]       out_rdata_q;
  logic              out_err_q;

  logic              illegal_d;
  logic              misalign_d;
  logic [3:0]        wstrb_d;
  logic [31:0]       wdata_d;
  logic [7:0]        byte_sel_d;
  logic [15:0]       half_sel_d;
  logic [31:0]       load_d;

  // Decode of the op presented in IDLE; only ever captured into registers.
  always_comb begin
    illegal_d  = 1'b0;
    misalign_d = 1'b0;
    wstrb_d    = 4'b0000;
    wdata_d    = in_wdata;
    case (in_funct3)
      3'b000: begin
        wstrb_d = 4'b0001 << in_addr[1:0];
        wdata_d = {4{in_wdata[7:0]}};
      end
      3'b001: begin
        misalign_d = in_addr[0];
        wstrb_d    = 4'b0011 << in_addr[1:0];
        wdata_d    = {2{in_wdata[15:0]}};
      end
      3'b010: begin
        misalign_d = |in_addr[1:0];
        wstrb_d    = 4'b1111;
      end
      3'b100: illegal_d = in_is_store;
      3'b101: begin
        illegal_d  = in_is_store;
        misalign_d = in_addr[0];
      end
      default: illegal_d = 1'b1;
    endcase
    if (!in_is_store) begin
      wstrb_d = 4'b0000;
    end
  end

  always_comb begin
    byte_sel_d = mem_rdata[7:0];
    case (off_q)
      2'd0: byte_sel_d = mem_rdata[7:0];
      2'd1: byte_sel_d = mem_rdata[15:8];
      2'd2: byte_sel_d = mem_rdata[23:16];
      2'd3: byte_sel_d = mem_rdata[31:24];
      default: byte_sel_d = mem_rdata[7:0];
    endcase
    half_sel_d = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_d = {{24{byte_sel_d[7]}}, byte_sel_d};
      3'b100:  load_d = {24'h000000, byte_sel_d};
      3'b001:  load_d = {{16{half_sel_d[15]}}, half_sel_d};
      3'b101:  load_d = {16'h0000, half_sel_d};
      default: load_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      mem_wen_q   <= 1'b0;
      out_rdata_q <= 32'h0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            is_store_q  <= in_is_store;
            funct3_q    <= in_funct3;
            off_q       <= in_addr[1:0];
            out_rdata_q <= 32'h0;
            if (illegal_d || misalign_d) begin
              out_err_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              mem_addr_q  <= {in_addr[31:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_wstrb_q <= wstrb_d;
              mem_wen_q   <= in_is_store;
              out_err_q   <= 1'b0;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the final counted cycle still beats the timeout.
          if (mem_rsp_valid) begin
            out_rdata_q <= is_store_q ? 32'h0 : load_d;
            out_err_q   <= 1'b0;
            state_q     <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            out_rdata_q <= 32'h0;
            out_err_q   <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign out_valid     = (state_q == S_DONE);
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign out_rdata     = out_rdata_q;
  assign out_err       = out_err_q;

endmodule
